// File: rtl/uart_receiver_pkg.sv
// Shared types and constants for the UART receive path: FSM state encoding,
// oversampling constants and a width helper.
package uart_receiver_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  localparam int unsigned MID_SAMPLE = 7;
  localparam int unsigned OVERSAMPLE = 16;

  // Counter width able to hold 0..v-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/uart_rx.sv
// Oversampled serial receive FSM: start-bit qualification at mid-bit, DATA bits
// shifted in LSB first, stop bit sampled and reported with a one-cycle rx_done_tick.
module uart_rx
  import uart_receiver_pkg::*;
#(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  output logic            rx_done_tick,
  output logic [DBIT-1:0] dout,
  output logic            stop_bit
);

  localparam int unsigned S_W = cnt_width((SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE);
  localparam int unsigned N_W = cnt_width(DBIT);

  state_t          state_q, state_d;
  logic [S_W-1:0]  s_q, s_d;
  logic [N_W-1:0]  n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    s_d          = s_q;
    n_d          = n_q;
    b_d          = b_q;
    rx_done_tick = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rx) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          // Line must still be low at mid start bit, otherwise treat as a glitch.
          if (s_q == S_W'(MID_SAMPLE)) begin
            if (!rx) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == S_W'(OVERSAMPLE - 1)) begin
            s_d = '0;
            b_d = {rx, b_q[DBIT-1:1]};
            if (n_q == N_W'(DBIT - 1)) begin
              state_d = STOP;
            end else begin
              n_d = n_q + N_W'(1);
            end
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_q == S_W'(SB_TICK - 1)) begin
            state_d      = IDLE;
            rx_done_tick = 1'b1;
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dout     = b_q;
  // Meaningful only alongside rx_done_tick, which marks the stop-bit sample point.
  assign stop_bit = rx;

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: baud tick generator, serial FSM and a first-word-fall-through FIFO
// with sticky frame/overrun flags. Define UART_RX_SYNC_EN to add a 2-flop rx synchronizer.
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int unsigned DBIT     = 8,
  parameter int unsigned SB_TICK  = 16,
  parameter int unsigned DVSR     = 163,
  parameter int unsigned DVSR_BIT = 8,
  parameter int unsigned FIFO_W   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       rd_uart,
  input  logic       clr_err,
  output logic [7:0] r_data,
  output logic       rx_empty,
  output logic       rx_full,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned DEPTH = 1 << FIFO_W;

  logic rx_fsm;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_q, sync_d;

  assign sync_d = {sync_q[0], rx};

  always_ff @(posedge clk) begin
    if (reset) sync_q <= '1;
    else       sync_q <= sync_d;
  end

  assign rx_fsm = sync_q[1];
`else
  assign rx_fsm = rx;
`endif

  logic [DVSR_BIT-1:0] cnt_q, cnt_d;
  logic                tick;

  assign tick  = (cnt_q == DVSR_BIT'(DVSR - 1));
  assign cnt_d = tick ? '0 : cnt_q + DVSR_BIT'(1);

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  logic            rx_done;
  logic [DBIT-1:0] rx_word;
  logic            stop_bit;

  uart_rx #(
    .DBIT    (DBIT),
    .SB_TICK (SB_TICK)
  ) u_rx (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx_fsm),
    .s_tick       (tick),
    .rx_done_tick (rx_done),
    .dout         (rx_word),
    .stop_bit     (stop_bit)
  );

  // Pointers carry one extra wrap bit so all 2^FIFO_W slots are usable.
  logic [FIFO_W:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DBIT-1:0] mem_q [DEPTH];
  logic [DBIT-1:0] mem_d [DEPTH];
  logic            empty, full, rd_en, wr_en;
  logic            frame_err_q, frame_err_d, overrun_q, overrun_d;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[FIFO_W] != rd_ptr_q[FIFO_W]) &&
                 (wr_ptr_q[FIFO_W-1:0] == rd_ptr_q[FIFO_W-1:0]);
  assign rd_en = rd_uart && !empty;
  // When full, a same-cycle pop frees the head slot, which is exactly where the write lands.
  assign wr_en = rx_done && (!full || rd_en);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) begin
      mem_d[wr_ptr_q[FIFO_W-1:0]] = rx_word;
      wr_ptr_d = wr_ptr_q + (FIFO_W+1)'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + (FIFO_W+1)'(1);
    end
  end

  always_comb begin
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;
    if (clr_err) begin
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
    end
    if (rx_done && !stop_bit)        frame_err_d = 1'b1;
    if (rx_done && full && !rd_en)   overrun_d   = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    r_data            = '0;
    r_data[DBIT-1:0]  = mem_q[rd_ptr_q[FIFO_W-1:0]];
  end

  assign rx_empty  = empty;
  assign rx_full   = full;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: frame-level reference FIFO model, directed
// corner cases followed by randomized frames, reads and error clears.
module tb_uart_receiver;
  import uart_receiver_pkg::*;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned BIT_CYC = 64;

  logic       clk = 1'b0;
  logic       reset, rx, rd_uart, clr_err;
  logic [7:0] r_data;
  logic       rx_empty, rx_full, frame_err, overrun;

  always #5 clk = ~clk;

  uart_receiver #(
    .DBIT     (8),
    .SB_TICK  (16),
    .DVSR     (4),
    .DVSR_BIT (8),
    .FIFO_W   (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .rd_uart   (rd_uart),
    .clr_err   (clr_err),
    .r_data    (r_data),
    .rx_empty  (rx_empty),
    .rx_full   (rx_full),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  logic       exp_ferr = 1'b0;
  logic       exp_ovr  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every accepted pop must present the oldest word the model holds.
  always @(negedge clk) begin
    if (rd_uart && !rx_empty) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL pop_unexpected: actual=%0h required=none", r_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (r_data !== e) begin
          failures++;
          $display("FAIL pop_data: actual=%0h required=%0h", r_data, e);
        end
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_frame(input logic [7:0] data, input bit good_stop);
    if (!good_stop) exp_ferr = 1'b1;
    if (exp_q.size() < DEPTH) exp_q.push_back(data);
    else                      exp_ovr = 1'b1;
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_ferr = 1'b0;
    exp_ovr  = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] data, input bit good_stop);
    rx = 1'b0;
    wait_cycles(BIT_CYC);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      wait_cycles(BIT_CYC);
    end
    if (good_stop) begin
      rx = 1'b1;
      wait_cycles(BIT_CYC);
    end else begin
      rx = 1'b0;
      wait_cycles(48);
      rx = 1'b1;
      wait_cycles(16);
    end
    wait_cycles(BIT_CYC);
    model_frame(data, good_stop);
  endtask

  task automatic read_one();
    rd_uart = 1'b1;
    wait_cycles(1);
    rd_uart = 1'b0;
    wait_cycles(1);
  endtask

  task automatic clear_errors();
    clr_err = 1'b1;
    wait_cycles(1);
    clr_err = 1'b0;
    exp_ferr = 1'b0;
    exp_ovr  = 1'b0;
    wait_cycles(1);
  endtask

  task automatic read_at_done();
    bit found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(posedge clk);
      #1;
      if (dut.rx_done) begin
        found   = 1'b1;
        rd_uart = 1'b1;
        @(posedge clk);
        #1;
        rd_uart = 1'b0;
      end
    end
    check("rx_done_seen", 32'(found), 32'd1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_empty"}, 32'(rx_empty), 32'd1);
    check({tag, "_full"},  32'(rx_full),  32'd0);
    check({tag, "_ferr"},  32'(frame_err), 32'd0);
    check({tag, "_ovr"},   32'(overrun),  32'd0);
  endtask

  task automatic check_status(input string tag);
    check({tag, "_empty"}, 32'(rx_empty),  32'(exp_q.size() == 0));
    check({tag, "_full"},  32'(rx_full),   32'(exp_q.size() == DEPTH));
    check({tag, "_ferr"},  32'(frame_err), 32'(exp_ferr));
    check({tag, "_ovr"},   32'(overrun),   32'(exp_ovr));
    if (exp_q.size() > 0) check({tag, "_head"}, 32'(r_data), 32'(exp_q[0]));
  endtask

  initial begin
    reset   = 1'b1;
    rx      = 1'b1;
    rd_uart = 1'b0;
    clr_err = 1'b0;
    wait_cycles(3);
    check_reset_state("reset");
    reset = 1'b0;
    model_reset();
    wait_cycles(10);

    // Single good frame.
    send_frame(8'hA5, 1'b1);
    check_status("a5");
    read_one();
    check_status("a5_read");

    // Short low glitch in idle must not start a frame.
    rx = 1'b0;
    wait_cycles(20);
    rx = 1'b1;
    wait_cycles(200);
    check_status("glitch");
    check("glitch_fsm_idle", 32'(dut.u_rx.state_q), 32'(IDLE));

    // Pop while empty is ignored.
    read_one();
    check_status("rd_empty");

    // Bad stop bit: word kept, frame_err raised, then cleared.
    send_frame(8'h3C, 1'b0);
    check_status("ferr");
    clear_errors();
    check_status("ferr_clr");
    read_one();

    // Fill the FIFO and overflow it.
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1);
      if (i == 4) check_status("fill4");
    end
    check_status("overflow");
    for (int i = 0; i < 4; i++) read_one();
    check_status("drained");
    clear_errors();
    check_status("ovr_clr");

    // Full FIFO with a pop in the same cycle as the write.
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
    check_status("full_again");
    fork
      send_frame(8'h05, 1'b1);
      read_at_done();
    join
    check_status("rd_wr_full");
    for (int i = 0; i < 4; i++) read_one();
    check_status("rd_wr_drained");

    // Reset in the middle of a frame abandons it.
    rx = 1'b0;
    wait_cycles(BIT_CYC);
    rx = 1'b1;
    wait_cycles(3 * BIT_CYC + 32);
    reset = 1'b1;
    wait_cycles(2);
    check_reset_state("mid_reset");
    reset = 1'b0;
    model_reset();
    wait_cycles(32 + 5 * BIT_CYC);
    check_status("post_reset");
    check("post_reset_fsm_idle", 32'(dut.u_rx.state_q), 32'(IDLE));
    send_frame(8'h5A, 1'b1);
    check_status("after_reset_5a");
    read_one();

    // Randomized traffic.
    for (int it = 0; it < 30; it++) begin
      logic [7:0] d;
      bit         good;
      int         nrd;
      d    = 8'($urandom);
      good = ($urandom_range(0, 7) != 0);
      wait_cycles($urandom_range(0, 90));
      send_frame(d, good);
      nrd = $urandom_range(0, 2);
      for (int r = 0; r < nrd; r++) read_one();
      if ($urandom_range(0, 5) == 0) clear_errors();
      check_status("rand");
    end

    for (int r = 0; r < DEPTH; r++) begin
      if (exp_q.size() > 0) read_one();
    end
    check_status("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
